// File: rtl/local_mac_pkg.sv
// local_mac_pkg: shared state encoding and local_mac interface widths
package local_mac_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_e;
  localparam int LM_RWL_W = 8;
  localparam int LM_CD_W = 12;
  localparam int LM_MAC_W = 14;
endpackage

// File: rtl/act_plane_shifter.sv
// act_plane_shifter: parallel-load activation register emitting one MSB-first bit-plane per shift
module act_plane_shifter #(
  parameter int N_LANE = 8,
  parameter int ACT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       shift,
  input  logic [N_LANE*ACT_BITS-1:0] din,
  output logic [N_LANE-1:0]          plane,
  output logic                       first,
  output logic                       last
);
  localparam int CW = $clog2(ACT_BITS);
  logic [N_LANE*ACT_BITS-1:0] sr_q, sr_d, src;
  logic [CW-1:0] cnt_q, cnt_d;
  // a load emits the MSB plane of din directly; every emit leaves the lanes shifted left by one
  always_comb begin
    src = load ? din : sr_q;
    plane = '0;
    sr_d = sr_q;
    for (int i = 0; i < N_LANE; i++) begin
      plane[i] = src[i*ACT_BITS+ACT_BITS-1];
      sr_d[i*ACT_BITS +: ACT_BITS] = (load || shift) ? {src[i*ACT_BITS +: ACT_BITS-1], 1'b0} : sr_q[i*ACT_BITS +: ACT_BITS];
    end
    cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    first = cnt_q == '0;
    last = cnt_q == CW'(ACT_BITS-1);
  end
  // plane register and emitted-plane counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/local_mac_driver.sv
// local_mac_driver: bit-serial activation sequencer for local_mac; define ACC_SAT_EN to saturate acc_out instead of wrapping
module local_mac_driver
  import local_mac_pkg::*;
#(
  parameter int N_LANE = LM_RWL_W,
  parameter int ACT_BITS = 8,
  parameter int MAC_W = LM_MAC_W,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANE*ACT_BITS-1:0] act_vec,
  input  logic                       act_signed,
  input  logic                       w_signed,
  output logic [N_LANE-1:0]          drv_rwlb_row0,
  output logic [N_LANE-1:0]          drv_rwlb_row1,
  output logic                       drv_sus,
  output logic                       drv_op_sel,
  output logic [LM_CD_W-1:0]         drv_C_in,
  output logic [LM_CD_W-1:0]         drv_D_in,
  input  logic [MAC_W-1:0]           mac_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           acc_out,
  output logic                       busy
);
  state_e state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic sus_q, sus_d, as_q, as_d, smp_q, smp_d, fst_q, fst_d;
  logic [N_LANE-1:0] row0_q, row0_d, plane;
  logic [ACC_W-1:0] acc_q, acc_d, s;
  logic [OUT_W-1:0] acc_out_q, acc_out_d, sat;
  logic accept, shift, first, last;
  act_plane_shifter #(.N_LANE(N_LANE), .ACT_BITS(ACT_BITS)) u_shift (
    .clk(clk), .rst(rst), .load(accept), .shift(shift), .din(act_vec),
    .plane(plane), .first(first), .last(last)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: accept, walk every plane, one drain cycle, then hold the result until taken
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? DRIVE : IDLE) :
              state_q == DRIVE ? (last ? DRAIN : DRIVE) :
              state_q == DRAIN ? DONE : (out_ready ? IDLE : DONE);
  end
  // output decode: rows, handshakes and the capture strobes that trail each plane by one cycle
  always_comb begin
    accept = in_valid && in_ready_q;
    shift = state_q == DRIVE && !last;
    row0_d = (accept || shift) ? ~plane : '1;
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
    sus_d = accept ? w_signed : sus_q;
    as_d = accept ? act_signed : as_q;
    smp_d = state_q == DRIVE;
    fst_d = state_q == DRIVE && first;
  end
`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2**(OUT_W-1)-1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic [ACC_W-1:0] UMAX = ACC_W'(2**OUT_W-1);
`endif
  // shift-accumulate samples; the MSB plane of a signed activation carries negative weight
  always_comb begin
    s = {{(ACC_W-MAC_W){sus_q & mac_result[MAC_W-1]}}, mac_result};
    acc_d = !smp_q ? acc_q : fst_q ? (as_q ? -s : s) : (acc_q << 1) + s;
`ifdef ACC_SAT_EN
    sat = (as_q | sus_q) ?
          ($signed(acc_d) > SMAX ? SMAX[OUT_W-1:0] : $signed(acc_d) < SMIN ? SMIN[OUT_W-1:0] : acc_d[OUT_W-1:0]) :
          (acc_d > UMAX ? UMAX[OUT_W-1:0] : acc_d[OUT_W-1:0]);
`else
    sat = acc_d[OUT_W-1:0];
`endif
    acc_out_d = state_q == DRAIN ? sat : acc_out_q;
  end
  // registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      row0_q <= '1;
      sus_q <= 1'b0;
      as_q <= 1'b0;
      smp_q <= 1'b0;
      fst_q <= 1'b0;
      acc_q <= '0;
      acc_out_q <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      row0_q <= row0_d;
      sus_q <= sus_d;
      as_q <= as_d;
      smp_q <= smp_d;
      fst_q <= fst_d;
      acc_q <= acc_d;
      acc_out_q <= acc_out_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign drv_rwlb_row0 = row0_q;
  assign drv_rwlb_row1 = '1;
  assign drv_sus = sus_q;
  assign drv_op_sel = 1'b0;
  assign drv_C_in = '0;
  assign drv_D_in = '0;
  assign acc_out = acc_out_q;
endmodule

// File: tb/tb_local_mac_driver.sv
// tb_local_mac_driver: randomized bench for local_mac_driver against a dot-product reference model
module tb_local_mac_driver;
  localparam int AB = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, act_signed = 1'b0, w_signed = 1'b0, out_ready = 1'b0;
  logic in_ready, drv_sus, drv_op_sel, out_valid, busy;
  logic [63:0] act_vec = '0;
  logic [7:0] row0, row1;
  logic [11:0] c_in, d_in;
  logic [13:0] mac_result = '0;
  logic [15:0] acc_out;
  int checks = 0, failures = 0, w = 0;
  always #5 clk = ~clk;
  local_mac_driver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .act_vec(act_vec),
    .act_signed(act_signed), .w_signed(w_signed), .drv_rwlb_row0(row0), .drv_rwlb_row1(row1),
    .drv_sus(drv_sus), .drv_op_sel(drv_op_sel), .drv_C_in(c_in), .drv_D_in(d_in),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
  );
  // local_mac stand-in: every lane has weight w, result registered one cycle after the plane
  always @(posedge clk) mac_result <= 14'(w * $countones(~row0));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [63:0] v, input bit as, input bit ws, input int wt);
    longint e = 0;
    for (int i = 0; i < 8; i++)
      e += longint'(wt) * (as ? longint'($signed(v[i*8 +: 8])) : longint'(v[i*8 +: 8]));
`ifdef ACC_SAT_EN
    if (as | ws) e = e > 32767 ? 32767 : e < -32768 ? -32768 : e;
    else if (e > 65535) e = 65535;
`endif
    return e[15:0];
  endfunction
  function automatic logic [7:0] plane_row(input logic [63:0] v, input int b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ~v[i*8+b];
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic [63:0] v, input bit as, input bit ws, input int wt, input int hold, input bit poke);
    int n;
    logic [15:0] exp;
    logic [7:0] rows [16];
    w = wt;
    exp = model(v, as, ws, wt);
    n = 0;
    while (!in_ready && n < 30) begin
      step;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    act_vec = v;
    act_signed = as;
    w_signed = ws;
    in_valid = 1'b1;
    out_ready = hold == 0;
    step;
    in_valid = 1'b0;
    act_vec = {$urandom, $urandom};
    act_signed = ~as;
    w_signed = ~ws;
    check("sus", drv_sus, ws);
    check("busy", busy, 1);
    check("in_ready_lo", in_ready, 0);
    n = 1;
    while (!out_valid && n < 40) begin
      if (n < 16) rows[n] = row0;
      step;
      n++;
    end
    check("latency", n, AB + 2);
    for (int k = 1; k <= AB; k++) check($sformatf("row0_c%0d", k), rows[k], plane_row(v, AB - k));
    check("row0_drain", rows[AB+1], 8'hFF);
    check("acc_out", acc_out, exp);
    if (hold == 0) begin
      step;
      check("done_1cyc", out_valid, 0);
      check("in_ready_after", in_ready, 1);
    end else begin
      for (int k = 0; k < hold; k++) begin
        if (poke) begin
          in_valid = 1'b1;
          act_vec = ~v;
        end
        step;
        check("hold_valid", out_valid, 1);
        check("hold_stable", acc_out, exp);
        check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      check("ack_valid", out_valid, 0);
      check("ack_ready", in_ready, 1);
      check("ack_busy", busy, 0);
    end
  endtask
  initial begin
    bit seen;
    bit ws;
    int wt;
    repeat (3) step;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sus", drv_sus, 0);
    check("rst_row0", row0, 8'hFF);
    check("rst_row1", row1, 8'hFF);
    check("rst_consts", {drv_op_sel, c_in, d_in}, 0);
    rst = 1'b0;
    step;
    txn({8{8'h03}}, 0, 0, 1, 2, 0);
    check("t1_acc", acc_out, 24);
    txn({8{8'hFF}}, 1, 0, 1, 1, 0);
    check("t2_acc", acc_out, 16'hFFF8);
    txn({8{8'hFF}}, 0, 0, 100, 1, 0);
`ifdef ACC_SAT_EN
    check("t3_acc", acc_out, 16'hFFFF);
`else
    check("t3_acc", acc_out, 16'h1CE0);
`endif
    txn({$urandom, $urandom}, 0, 1, 37, 5, 1);
    w = 1;
    act_vec = {8{8'h55}};
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_row0", row0, 8'hFF);
    check("mrst_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (12) begin
      step;
      seen |= out_valid;
    end
    check("mrst_no_valid", seen, 0);
    txn({8{8'h55}}, 0, 0, 3, 1, 0);
    txn({$urandom, $urandom}, 1, 1, -77, 0, 0);
    txn({$urandom, $urandom}, 0, 1, 500, 0, 0);
    txn(64'h0, 1, 1, -5, 0, 0);
    check("zero_acc", acc_out, 0);
    repeat (20) begin
      ws = 1'($urandom % 2);
      wt = ws ? int'($urandom_range(0, 2046)) - 1023 : int'($urandom_range(0, 2047));
      txn({$urandom, $urandom}, 1'($urandom % 2), ws, wt, int'($urandom_range(0, 3)), 1'($urandom % 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
